mult_wb_buffer: RTL and testbench
=================================

// Module: mult_wb_buffer
// PURPOSE
//   Writeback buffer directly downstream of the single-cycle-latency multiplier.
//   The multiplier has no backpressure, so this block captures every valid
//   result/trans_id in a small FIFO and drains it to the writeback port under
//   valid/ready. It issues credit-based issue_ready_o upstream so that no
//   result can ever arrive while the buffer is full.
// PARAMETERS
//   DEPTH   4              FIFO entries; power of two, >= 2
//   DATA_W  64             result width
//   TID_W   TRANS_ID_BITS  transaction-id width (from ariane_pkg)
// PORTS
//   clk_i            in   1                 clock, rising edge
//   rst_i            in   1                 synchronous reset, active-high
//   flush_i          in   1                 pipeline flush: discard buffered and in-flight ops
//   issue_valid_i    in   1                 op handed to multiplier this cycle
//   issue_ready_o    out  1                 buffer can absorb one more op
//   mult_valid_i     in   1                 multiplier result valid (multiplier's mult_valid_o)
//   mult_result_i    in   DATA_W            multiplier result
//   mult_trans_id_i  in   TID_W             multiplier trans id
//   wb_valid_o       out  1                 writeback entry valid
//   wb_ready_i       in   1                 writeback consumer accepts
//   wb_result_o      out  DATA_W            head result
//   wb_trans_id_o    out  TID_W             head trans id
//   count_o          out  $clog2(DEPTH)+1   occupied entries
//   overflow_o       out  1                 sticky: a result was dropped
// BEHAVIOUR
//   Reset (rst_i=1 at clk edge): count=0, rd/wr ptrs=0, inflight_q=0,
//     overflow_o=0, wb_valid_o=0, wb_result_o=0, wb_trans_id_o=0,
//     issue_ready_o=1 (first cycle after reset). Reset mid-drain drops all entries.
//   Credit: inflight_q <= issue_valid_i & issue_ready_o & ~flush_i.
//     issue_ready_o = (count_q + inflight_q) < DEPTH; driven only from
//     registers, no combinational path from any input.
//     issue_valid_i while issue_ready_o=0 is ignored for credit.
//   Push: mult_valid_i & ~flush_i. Pop: wb_valid_o & wb_ready_i.
//   Push and pop in the same cycle: both take effect, count unchanged, even at full.
//   Full (count=DEPTH) with push and no pop: result dropped, overflow_o<=1,
//     and it stays 1 until rst_i. Unreachable under correct credit use.
//   Empty: no bypass. A push at edge N shows wb_valid_o=1 after edge N,
//     i.e. one cycle of buffer latency. wb_valid_o = (count_q != 0).
//   Hold: while wb_valid_o & ~wb_ready_i, wb_result_o/wb_trans_id_o are stable.
//   Ordering: strict FIFO; trans ids leave in arrival order.
//   Pointers: $clog2(DEPTH) bits, wrap naturally; full/empty come from count_q.
//   Flush: next cycle count=0, ptrs=0, inflight_q=0, wb_valid_o=0. Any push
//     or pop in the flush cycle is discarded. overflow_o is unaffected.
//   wb_result_o/wb_trans_id_o show the head entry, don't-care when wb_valid_o=0.
// STRUCTURE
//   ariane_pkg: add typedef struct packed {logic [TRANS_ID_BITS-1:0] trans_id;
//     logic [63:0] result;} mult_wb_entry_t.
//   Sub-module wb_fifo: generic sync FIFO (DEPTH, entry type) with push, pop,
//     flush, count, full, empty. Top level adds credit logic, overflow flag,
//     port mapping.
// TESTING
//   1 Reset, then issue 1 op; mult_valid_i next cycle with result 0xDEAD, tid 3
//     -> wb_valid_o=1 one cycle later, wb_result_o=0xDEAD, wb_trans_id_o=3.
//   2 wb_ready_i=0; issue every cycle ready allows (DEPTH=4)
//     -> exactly 4 ops accepted, issue_ready_o=0 from the cycle
//     count_q+inflight_q reaches 4, no overflow_o.
//   3 Buffer full, wb_ready_i=1 and mult_valid_i=1 in the same cycle
//     -> count stays 4, head advances, new entry at tail, overflow_o=0.
//   4 Force mult_valid_i at full with wb_ready_i=0 -> entry dropped,
//     overflow_o=1 and sticky across flush_i, cleared only by rst_i.
//   5 3 entries buffered plus 1 in flight, assert flush_i -> next cycle count_o=0,
//     wb_valid_o=0, issue_ready_o=1, late mult_valid_i in flush cycle not stored.
//   6 Random wb_ready_i, tids 0..15 in order -> wb_trans_id_o sequence 0..15,
//     head stable whenever stalled.

Source files
------------

// File: rtl/mult_wb_buffer_pkg.sv
// Shared types for the multiplier writeback buffer.
package mult_wb_buffer_pkg;

  localparam int TRANS_ID_BITS = 4;
  localparam int RESULT_W      = 64;

  // One buffered multiplier result with the transaction it belongs to.
  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [RESULT_W-1:0]      result;
  } mult_wb_entry_t;

endpackage

// File: rtl/mult_wb_buffer_wb_fifo.sv
// Generic synchronous FIFO: power-of-two depth, occupancy counter,
// free-running wrapping pointers, flush clears state in one cycle.
module mult_wb_buffer_wb_fifo
  import mult_wb_buffer_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = mult_wb_entry_t,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush,
  input  logic             push,
  input  entry_t           wdata,
  input  logic             pop,
  output entry_t           rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push at full is accepted only when a pop frees the head slot in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy bookkeeping; flush and reset both empty the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (!do_push && do_pop) count_q <= count_q - 1'b1;
    end
  end

  // Entry storage; contents need no reset since occupancy gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mult_wb_buffer.sv
// Writeback buffer behind the single-cycle multiplier: absorbs every result,
// drains under valid/ready, and grants issue credit so the FIFO never overflows.
module mult_wb_buffer
  import mult_wb_buffer_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter int  DATA_W = RESULT_W,
  parameter int  TID_W  = TRANS_ID_BITS,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  input  logic              mult_valid_i,
  input  logic [DATA_W-1:0] mult_result_i,
  input  logic [TID_W-1:0]  mult_trans_id_i,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic [DATA_W-1:0] wb_result_o,
  output logic [TID_W-1:0]  wb_trans_id_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  mult_wb_entry_t   push_entry;
  mult_wb_entry_t   head_entry;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   credit_used;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             inflight_q;
  logic             overflow_q;

  assign push                = mult_valid_i & ~flush_i;
  assign pop                 = wb_valid_o & wb_ready_i;
  assign push_entry.trans_id = mult_trans_id_i;
  assign push_entry.result   = mult_result_i;

  mult_wb_buffer_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (mult_wb_entry_t)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .flush (flush_i),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head_entry),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Occupied slots plus the op still inside the multiplier; purely registered.
  assign credit_used   = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign issue_ready_o = (credit_used < (CNT_W + 1)'(DEPTH));

  assign wb_valid_o    = ~empty;
  // Head is zeroed while empty so the outputs read 0 straight out of reset.
  assign wb_result_o   = wb_valid_o ? head_entry.result   : '0;
  assign wb_trans_id_o = wb_valid_o ? head_entry.trans_id : '0;
  assign count_o       = count;
  assign overflow_o    = overflow_q;

  // Track the op accepted this cycle; its result lands in the FIFO next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) inflight_q <= 1'b0;
    else       inflight_q <= issue_valid_i & issue_ready_o & ~flush_i;
  end

  // Sticky drop flag: a result arrived at full with no pop to make room.
  always_ff @(posedge clk_i) begin
    if (rst_i)                    overflow_q <= 1'b0;
    else if (push && full && !pop) overflow_q <= 1'b1;
  end

endmodule

// File: tb/tb_mult_wb_buffer.sv
// Bench for mult_wb_buffer: queue-based reference model plus scoreboard monitor.
module tb_mult_wb_buffer;
  import mult_wb_buffer_pkg::*;

  localparam int DEPTH  = 4;
  localparam int DATA_W = RESULT_W;
  localparam int TID_W  = TRANS_ID_BITS;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              flush_i = 1'b0;
  logic              issue_valid_i = 1'b0;
  logic              issue_ready_o;
  logic              mult_valid_i = 1'b0;
  logic [DATA_W-1:0] mult_result_i = '0;
  logic [TID_W-1:0]  mult_trans_id_i = '0;
  logic              wb_valid_o;
  logic              wb_ready_i = 1'b0;
  logic [DATA_W-1:0] wb_result_o;
  logic [TID_W-1:0]  wb_trans_id_o;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;

  always #5 clk_i = ~clk_i;

  mult_wb_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TID_W(TID_W)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .issue_valid_i   (issue_valid_i),
    .issue_ready_o   (issue_ready_o),
    .mult_valid_i    (mult_valid_i),
    .mult_result_i   (mult_result_i),
    .mult_trans_id_i (mult_trans_id_i),
    .wb_valid_o      (wb_valid_o),
    .wb_ready_i      (wb_ready_i),
    .wb_result_o     (wb_result_o),
    .wb_trans_id_o   (wb_trans_id_o),
    .count_o         (count_o),
    .overflow_o      (overflow_o)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
  endtask

  // Reference model: expected FIFO contents, occupancy, credit and sticky flag.
  typedef struct {
    logic [TID_W-1:0]  tid;
    logic [DATA_W-1:0] res;
  } exp_t;

  exp_t             sb_q[$];
  logic [TID_W-1:0] pop_log[$];
  int               m_cnt  = 0;
  bit               m_infl = 1'b0;
  bit               m_ovf  = 1'b0;
  bit               m_ready;
  bit               m_pop;
  bit               mon_en = 1'b0;

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_cnt  = 0;
      m_infl = 1'b0;
      m_ovf  = 1'b0;
      sb_q.delete();
    end else begin
      m_ready = (m_cnt + int'(m_infl)) < DEPTH;
      m_pop   = wb_ready_i && (m_cnt > 0) && !flush_i;
      m_infl  = issue_valid_i && m_ready && !flush_i;
      if (flush_i) begin
        m_cnt = 0;
        sb_q.delete();
      end else if (mult_valid_i) begin
        if (m_cnt == DEPTH && !m_pop) m_ovf = 1'b1;
        else begin
          sb_q.push_back('{tid: mult_trans_id_i, res: mult_result_i});
          if (!m_pop) m_cnt++;
        end
      end else if (m_pop) begin
        m_cnt--;
      end
    end
  end

  // Monitor: status every cycle, head entry whenever the DUT presents one,
  // and the scoreboard entry is retired when the consumer takes it.
  always @(negedge clk_i) begin
    if (mon_en && !rst_i) begin
      check("wb_valid", 64'(wb_valid_o), 64'(m_cnt != 0));
      check("count", 64'(count_o), 64'(m_cnt));
      check("issue_ready", 64'(issue_ready_o), 64'((m_cnt + int'(m_infl)) < DEPTH));
      check("overflow", 64'(overflow_o), 64'(m_ovf));
    end
    if (!rst_i && m_cnt > 0 && sb_q.size() > 0) begin
      if (mon_en) begin
        check("head_tid", 64'(wb_trans_id_o), 64'(sb_q[0].tid));
        check("head_result", wb_result_o, sb_q[0].res);
      end
      if (wb_ready_i && !flush_i) begin
        pop_log.push_back(wb_trans_id_o);
        void'(sb_q.pop_front());
      end
    end
  end

  // Multiplier stand-in: a result follows one cycle after each accepted issue.
  logic [TID_W-1:0]  tid_ctr = '0;
  logic [DATA_W-1:0] res_ovr = '0;
  bit                use_ovr = 1'b0;

  task automatic cyc(input bit iv, input bit rdy, input bit fl, input bit force_mv);
    issue_valid_i   = iv;
    wb_ready_i      = rdy;
    flush_i         = fl;
    mult_valid_i    = m_infl | force_mv;
    mult_result_i   = use_ovr ? res_ovr : {$urandom, $urandom};
    mult_trans_id_i = tid_ctr;
    if (mult_valid_i) tid_ctr = tid_ctr + 1'b1;
    use_ovr = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int accepted;
    int first_block;
    int issued;
    int guard;

    // Reset state
    do_reset();
    mon_en = 1'b1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    check("rst_issue_ready", 64'(issue_ready_o), 64'd1);
    check("rst_overflow", 64'(overflow_o), 64'd0);
    check("rst_wb_result", wb_result_o, 64'd0);
    check("rst_wb_tid", 64'(wb_trans_id_o), 64'd0);

    // Single op: result 0xDEAD, tid 3, visible one cycle after arrival
    cyc(1, 0, 0, 0);
    check("s1_no_bypass_valid", 64'(wb_valid_o), 64'd0);
    tid_ctr = 3;
    res_ovr = 64'hDEAD;
    use_ovr = 1'b1;
    cyc(0, 0, 0, 0);
    check("s1_wb_valid", 64'(wb_valid_o), 64'd1);
    check("s1_wb_result", wb_result_o, 64'hDEAD);
    check("s1_wb_tid", 64'(wb_trans_id_o), 64'd3);
    cyc(0, 1, 0, 0);
    check("s1_drained", 64'(wb_valid_o), 64'd0);

    // Fill under stall: issue every cycle, only DEPTH ops may be accepted
    tid_ctr     = 0;
    accepted    = 0;
    first_block = -1;
    for (int i = 0; i < 8; i++) begin
      if (issue_ready_o) accepted++;
      else if (first_block < 0) first_block = i;
      cyc(1, 0, 0, 0);
    end
    check("s2_accepted", 64'(accepted), 64'(DEPTH));
    check("s2_first_block_cycle", 64'(first_block), 64'(DEPTH));
    check("s2_count_full", 64'(count_o), 64'(DEPTH));
    check("s2_no_overflow", 64'(overflow_o), 64'd0);
    check("s2_head_tid", 64'(wb_trans_id_o), 64'd0);

    // Push and pop together at full
    cyc(0, 1, 0, 1);
    check("s3_count", 64'(count_o), 64'(DEPTH));
    check("s3_head_advanced", 64'(wb_trans_id_o), 64'd1);
    check("s3_no_overflow", 64'(overflow_o), 64'd0);

    // Forced arrival at full with no pop: dropped, sticky overflow
    cyc(0, 0, 0, 1);
    check("s4_count", 64'(count_o), 64'(DEPTH));
    check("s4_overflow", 64'(overflow_o), 64'd1);
    cyc(0, 0, 1, 0);
    check("s4_flush_count", 64'(count_o), 64'd0);
    check("s4_overflow_after_flush", 64'(overflow_o), 64'd1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("s4_refill_count", 64'(count_o), 64'd2);
    do_reset();
    check("s4_overflow_after_reset", 64'(overflow_o), 64'd0);
    check("s4_reset_drops_entries", 64'(count_o), 64'd0);

    // Flush with three buffered and one in flight
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    check("s5_count_before", 64'(count_o), 64'd3);
    check("s5_ready_before", 64'(issue_ready_o), 64'd0);
    cyc(0, 0, 1, 0);
    check("s5_count", 64'(count_o), 64'd0);
    check("s5_wb_valid", 64'(wb_valid_o), 64'd0);
    check("s5_issue_ready", 64'(issue_ready_o), 64'd1);
    cyc(0, 0, 0, 0);
    check("s5_late_result_dropped", 64'(count_o), 64'd0);

    // Random backpressure, tids 0..15 must leave in order
    tid_ctr = 0;
    pop_log.delete();
    issued = 0;
    guard  = 0;
    while ((pop_log.size() < 16) && (guard < 400)) begin
      bit iv;
      iv = (issued < 16) && ($urandom_range(0, 3) != 0);
      if (iv && issue_ready_o) issued++;
      cyc(iv, 1'($urandom_range(0, 1)), 0, 0);
      guard++;
    end
    check("s6_drain_done", 64'(pop_log.size()), 64'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < pop_log.size()) check("s6_tid_order", 64'(pop_log[i]), 64'(i));
    end
    cyc(0, 0, 0, 0);
    check("s6_no_overflow", 64'(overflow_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
